// File: rtl/uart_cmd_scheduler.sv
// Command controller for the up-counter: merges button pulses and UART command
// bytes, drives run/clear through a STOP/RUN/CLEAR FSM and schedules TX replies.
module uart_cmd_scheduler #(
   parameter int CLR_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   input  logic       i_btn_run,
   input  logic       i_btn_clr,
   input  logic       i_tx_busy,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   output logic       o_run_on,
   output logic       o_clr_on,
   output logic       o_cmd_err
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } t_state;

   localparam logic [7:0] LP_CLR_LOAD = 8'(CLR_CYCLES - 1);

   t_state     r_state;
   t_state     w_next;
   logic       r_pend_valid;
   logic [7:0] r_pend_data;
   logic       r_rep_valid;
   logic [7:0] r_rep_data;
   logic [7:0] r_clr_cnt;
   logic       r_tx_start;
   logic [7:0] r_tx_data;
   logic       r_cmd_err;

   logic       w_tx_fire;
   logic       w_btn_take;
   logic       w_uart_take;
   logic       w_uart_err;
   logic [7:0] w_reply;

   // A UART byte may be consumed when the reply slot frees in the same cycle.
   always_comb begin
      w_tx_fire   = r_rep_valid && !i_tx_busy && !r_tx_start;
      w_btn_take  = (r_state != ST_CLEAR) && (i_btn_run || i_btn_clr);
      w_uart_take = r_pend_valid && (r_state != ST_CLEAR) && !w_btn_take &&
                    (!r_rep_valid || w_tx_fire);
   end

   always_comb begin
      w_reply    = 8'h45;
      w_uart_err = 1'b0;
      case (r_pend_data)
         8'h72:   w_reply = (r_state == ST_RUN) ? 8'h53 : 8'h52;
         8'h73:   w_reply = 8'h53;
         8'h63: begin
            if (r_state == ST_RUN) w_uart_err = 1'b1;
            else                   w_reply    = 8'h43;
         end
         8'h3F:   w_reply = (r_state == ST_RUN) ? 8'h52 : 8'h53;
         default: w_uart_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_STOP;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_STOP: begin
            if (i_btn_run)        w_next = ST_RUN;
            else if (i_btn_clr)   w_next = ST_CLEAR;
            else if (w_uart_take) begin
               if (r_pend_data == 8'h72)      w_next = ST_RUN;
               else if (r_pend_data == 8'h63) w_next = ST_CLEAR;
            end
         end
         ST_RUN: begin
            if (i_btn_run) w_next = ST_STOP;
            else if (w_uart_take && (r_pend_data == 8'h72 || r_pend_data == 8'h73))
               w_next = ST_STOP;
         end
         ST_CLEAR: begin
            if (r_clr_cnt == '0) w_next = ST_STOP;
         end
         default: w_next = ST_STOP;
      endcase
   end

   always_comb begin
      o_run_on = (r_state == ST_RUN);
      o_clr_on = (r_state == ST_CLEAR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_rep_valid  <= 1'b0;
         r_rep_data   <= '0;
         r_clr_cnt    <= '0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= '0;
         r_cmd_err    <= 1'b0;
      end else begin
         if (i_rx_done && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_data  <= i_rx_data;
         end else if (w_uart_take) begin
            r_pend_valid <= 1'b0;
         end

         if (w_uart_take) begin
            r_rep_valid <= 1'b1;
            r_rep_data  <= w_reply;
         end else if (w_tx_fire) begin
            r_rep_valid <= 1'b0;
         end

         r_tx_start <= w_tx_fire;
         if (w_tx_fire) r_tx_data <= r_rep_data;

         if (r_state != ST_CLEAR && w_next == ST_CLEAR)
            r_clr_cnt <= LP_CLR_LOAD;
         else if (r_state == ST_CLEAR && r_clr_cnt != '0)
            r_clr_cnt <= r_clr_cnt - 8'd1;

         r_cmd_err <= (i_rx_done && r_pend_valid) || (w_uart_take && w_uart_err);
      end
   end

   assign o_tx_start = r_tx_start;
   assign o_tx_data  = r_tx_data;
   assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Randomized bench for uart_cmd_scheduler: a command-level reference model
// predicts each cycle's controls; TX replies are checked through a scoreboard.
module tb_uart_cmd_scheduler;

   localparam int CLR = 4;
   localparam int M_STOP = 0, M_RUN = 1, M_CLEAR = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] i_rx_data;
   logic       i_rx_done, i_btn_run, i_btn_clr, i_tx_busy;
   logic       o_tx_start, o_run_on, o_clr_on, o_cmd_err;
   logic [7:0] o_tx_data;

   uart_cmd_scheduler #(.CLR_CYCLES(CLR)) dut (
      .clk(clk), .reset(reset),
      .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
      .i_btn_run(i_btn_run), .i_btn_clr(i_btn_clr), .i_tx_busy(i_tx_busy),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
      .o_run_on(o_run_on), .o_clr_on(o_clr_on), .o_cmd_err(o_cmd_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc = 0, tx_cnt = 0, burst = 0;

   // Reference model: mode, clear countdown, pending byte queue (cap 1), reply slot.
   int         m_mode, m_left;
   logic [7:0] m_pend[$];
   bit         m_rep_full, m_last_fire, exp_err, exp_txs;
   logic [7:0] m_rep, m_txd;
   logic [7:0] sb[$];
   logic [7:0] sb_exp;

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_STOP; m_left = 0; m_pend.delete();
      m_rep_full = 0; m_last_fire = 0; exp_err = 0; exp_txs = 0;
      m_rep = 8'h00; m_txd = 8'h00;
   endtask

   task automatic uart_cmd(logic [7:0] b);
      case (b)
         8'h72: if (m_mode == M_RUN) begin m_mode = M_STOP; m_rep = 8'h53; end
                else begin m_mode = M_RUN; m_rep = 8'h52; end
         8'h73: begin m_mode = M_STOP; m_rep = 8'h53; end
         8'h63: if (m_mode == M_RUN) begin m_rep = 8'h45; exp_err = 1; end
                else begin m_mode = M_CLEAR; m_left = CLR; m_rep = 8'h43; end
         8'h3F: m_rep = (m_mode == M_RUN) ? 8'h52 : 8'h53;
         default: begin m_rep = 8'h45; exp_err = 1; end
      endcase
      m_rep_full = 1;
      sb.push_back(m_rep);
   endtask

   task automatic model_step(bit rxd, logic [7:0] rxb, bit br, bit bc, bit busy);
      bit had_pend, fire;
      had_pend = (m_pend.size() != 0);
      fire     = m_rep_full && !busy && !m_last_fire;
      exp_err  = 0;
      if (fire) begin m_txd = m_rep; m_rep_full = 0; end
      if (m_mode == M_CLEAR) begin
         m_left--;
         if (m_left == 0) m_mode = M_STOP;
      end else if (br) begin
         m_mode = (m_mode == M_RUN) ? M_STOP : M_RUN;
      end else if (bc) begin
         if (m_mode == M_STOP) begin m_mode = M_CLEAR; m_left = CLR; end
      end else if (had_pend && !m_rep_full) begin
         uart_cmd(m_pend.pop_front());
      end
      if (rxd) begin
         if (had_pend) exp_err = 1;
         else          m_pend.push_back(rxb);
      end
      m_last_fire = fire;
      exp_txs     = fire;
   endtask

   task automatic cycle(bit rxd, logic [7:0] rxb, bit br, bit bc, bit fbusy);
      bit busy;
      busy = fbusy || (tx_cnt > 0);
      if (tx_cnt > 0) tx_cnt--;
      if (o_tx_start) tx_cnt = int'($urandom_range(1, 4));
      i_rx_done = rxd;
      i_rx_data = rxd ? rxb : 8'($urandom);
      i_btn_run = br;
      i_btn_clr = bc;
      i_tx_busy = busy;
      model_step(rxd, rxb, br, bc, busy);
      @(posedge clk); #1; cyc++;
      check("run_on",   int'(o_run_on),   int'(m_mode == M_RUN));
      check("clr_on",   int'(o_clr_on),   int'(m_mode == M_CLEAR));
      check("cmd_err",  int'(o_cmd_err),  int'(exp_err));
      check("tx_start", int'(o_tx_start), int'(exp_txs));
      check("tx_data",  int'(o_tx_data),  int'(m_txd));
   endtask

   task automatic rx(logic [7:0] b, bit fb);
      cycle(1'b1, b, 1'b0, 1'b0, fb);
   endtask

   task automatic idle(int n, bit fb);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, fb);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_run_on"},   int'(o_run_on),   0);
      check({tag, "_clr_on"},   int'(o_clr_on),   0);
      check({tag, "_cmd_err"},  int'(o_cmd_err),  0);
      check({tag, "_tx_start"}, int'(o_tx_start), 0);
      check({tag, "_tx_data"},  int'(o_tx_data),  0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_rx_done = 0; i_btn_run = 0; i_btn_clr = 0; i_tx_busy = 0;
      #1;
      check_zero("async_reset");
      model_reset();
      sb.delete();
      tx_cnt = 0; burst = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Scoreboard monitor: every transmitted byte must be the oldest outstanding reply.
   always @(negedge clk) begin
      if (!reset && o_tx_start) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_tx: got %h, expected no transmission", o_tx_data);
         end else begin
            sb_exp = sb.pop_front();
            if (o_tx_data !== sb_exp) begin
               n_fail++;
               $display("FAIL sb_tx: got %h expected %h", o_tx_data, sb_exp);
            end
         end
      end
   end

   initial begin
      bit rxd, br, bc, fb;
      logic [7:0] b;
      int sel;
      reset = 1'b1;
      i_rx_done = 0; i_rx_data = 8'h00; i_btn_run = 0; i_btn_clr = 0; i_tx_busy = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b0;

      rx(8'h72, 0); idle(8, 0);
      rx(8'h73, 0); idle(8, 0);
      rx(8'h63, 0); idle(10, 0);
      rx(8'h72, 0); idle(8, 0);
      rx(8'h63, 0); idle(8, 0);
      rx(8'h73, 0); idle(8, 0);

      cycle(1'b1, 8'h73, 1'b1, 1'b0, 1'b0); idle(8, 0);

      rx(8'h3F, 1); idle(1, 1); rx(8'h72, 1); idle(6, 1); idle(12, 0);

      rx(8'h3F, 1); idle(1, 1); rx(8'h72, 1); rx(8'h73, 1); idle(5, 1); idle(12, 0);

      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); idle(6, 0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); idle(2, 0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); rx(8'h72, 0); idle(10, 0);
      rx(8'h73, 0); idle(6, 0);

      rx(8'h63, 1); idle(2, 1);
      do_reset();
      idle(10, 0);

      for (int i = 0; i < 600; i++) begin
         rxd = ($urandom_range(0, 3) == 0);
         sel = int'($urandom_range(0, 5));
         case (sel)
            0: b = 8'h72;
            1: b = 8'h73;
            2: b = 8'h63;
            3: b = 8'h3F;
            default: b = 8'($urandom);
         endcase
         br = ($urandom_range(0, 11) == 0);
         bc = ($urandom_range(0, 11) == 0);
         if (burst == 0 && $urandom_range(0, 15) == 0) burst = int'($urandom_range(2, 10));
         fb = (burst > 0);
         if (burst > 0) burst--;
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle(rxd, b, br, bc, fb);
      end

      idle(40, 0);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_scheduler.md
Name: uart_cmd_scheduler

Overview:
- Command controller for the up-counter datapath. It merges push-button pulses and UART RX command bytes into one ordered command stream.
- It drives the counter's run/clear controls through a STOP/RUN/CLEAR state machine.
- It schedules one-byte acknowledgements onto the UART TX through a start/busy handshake, with backpressure.

Parameters:
- CLR_CYCLES, 4, number of cycles o_clr_on stays high per clear; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- i_rx_data  in  8  received UART byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe: byte received.
- i_btn_run  in  1  one-cycle debounced pulse: run/stop toggle.
- i_btn_clr  in  1  one-cycle debounced pulse: clear.
- i_tx_busy  in  1  UART TX busy; high from the cycle after o_tx_start until the byte is sent.
- o_tx_start  out  1  one-cycle TX start pulse.
- o_tx_data  out  8  TX byte; registered, stable from the o_tx_start cycle until the next o_tx_start.
- o_run_on  out  1  counter enable.
- o_clr_on  out  1  counter synchronous clear.
- o_cmd_err  out  1  one-cycle pulse on an invalid or dropped command.

Behaviour:
- Reset (async): state=STOP, pending empty, reply empty, clear counter=0. All outputs 0, including o_tx_data=8'h00.
- Outputs o_run_on and o_clr_on decode the state: STOP=00, RUN=10, CLEAR=01.
- UART path:
  - Edge N with i_rx_done=1 writes i_rx_data into a 1-deep pending register.
  - The pending byte is decoded at edge N+1, so the state/output change is visible 2 cycles after the strobe.
  - A strobe that arrives while pending is full drops the new byte, pulses o_cmd_err, and leaves pending unchanged.
- Button path: pulses are decoded directly, so the effect is visible 1 cycle after the pulse. Button commands produce no TX reply.
- Arbitration, per cycle, at most one command is consumed:
  - A button pulse wins over a pending UART byte; the UART byte stays pending.
  - If i_btn_run and i_btn_clr occur together, btn_run is taken and btn_clr is discarded silently.
- UART command table (reply byte in brackets):
  - 8'h72 'r': STOP->RUN ['R']; RUN->STOP ['S'].
  - 8'h73 's': RUN->STOP ['S']; STOP stays ['S'].
  - 8'h63 'c': STOP->CLEAR ['C']; in RUN, no change ['E'] plus o_cmd_err.
  - 8'h3F '?': no change; reply 'R' if RUN, else 'S'.
  - Any other byte: no change ['E'] plus o_cmd_err.
- Button commands: btn_run behaves as 'r' and btn_clr as 'c', but with no reply. btn_clr in RUN is ignored without error.
- CLEAR state:
  - Lasts exactly CLR_CYCLES cycles with o_clr_on=1, then goes to STOP.
  - Button pulses during CLEAR are ignored.
  - A pending UART byte is held, not consumed, until STOP is reached.
- Reply scheduling:
  - A 1-entry reply register holds the reply byte.
  - A UART command is consumed only if the reply register is empty, or is being emptied in the same cycle. Otherwise it stays pending (backpressure).
  - When the reply is valid and i_tx_busy=0, o_tx_start pulses one cycle, o_tx_data is loaded, and the reply register is freed.
  - o_tx_start never pulses while i_tx_busy=1, and never in two consecutive cycles.
- Reset mid-operation, including during CLEAR or with a reply pending: everything returns to reset values, the pending byte and reply are lost, and no o_tx_start is issued.

Test Plan:
- Reset, then rx 'r' with tx_busy=0 -> o_run_on=1 two cycles after i_rx_done; o_tx_start pulse with o_tx_data=8'h52.
- From STOP, rx 'c' with CLR_CYCLES=4 -> o_clr_on high exactly 4 cycles, then STOP; reply 8'h43. Repeat with 'c' in RUN -> state unchanged, o_cmd_err pulse, reply 8'h45.
- i_btn_run and i_rx_done('s') in the same cycle from STOP -> RUN first (no reply); next cycle 's' consumed -> STOP, reply 8'h53.
- Hold tx_busy=1, send '?' then 'r' -> first reply held, 'r' stays pending with o_run_on=0. Release busy -> reply 8'h53 sent, then 'r' consumed, then 8'h52 sent once busy drops again.
- Two i_rx_done strobes in back-to-back cycles while the reply register is full -> second byte dropped with o_cmd_err; first byte still processed later.
- Assert reset during CLEAR with a reply pending -> all outputs 0 immediately; no o_tx_start after release.
